// File: rtl/fpu_result_checker.sv
// fpu_result_checker: queues expected FPU results and classifies each incoming
// FPU result against the oldest queued value (exact / rounding / mismatch /
// orphan), keeping saturating per-class counters and sticky error flags.
// Ports:
//   CLK, RST                 clock (rising edge), synchronous active-high reset
//   exp_valid/exp_data       expected-value push; exp_ready = queue not full
//   res_valid/res_data       FPU result under check (pops the queue head)
//   status_valid/status      one-cycle pulse + held classification code
//   *_cnt                    saturating class counters
//   level                    queue occupancy
//   overflow, error          sticky flags (push while full / mismatch or orphan)
module fpu_result_checker #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned EXP_W    = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned TOL_BITS = 1,
  parameter int unsigned NAN_EQ   = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     exp_valid,
  input  logic [WIDTH-1:0]         exp_data,
  output logic                     exp_ready,
  input  logic                     res_valid,
  input  logic [WIDTH-1:0]         res_data,
  output logic                     status_valid,
  output logic [1:0]               status,
  output logic [CNT_W-1:0]         match_cnt,
  output logic [CNT_W-1:0]         round_cnt,
  output logic [CNT_W-1:0]         mismatch_cnt,
  output logic [CNT_W-1:0]         orphan_cnt,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     error
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned PTR_W  = IDX_W + 1;
  localparam int unsigned MANT_W = WIDTH - 1 - EXP_W;

  localparam logic [1:0] ST_EXACT    = 2'b00;
  localparam logic [1:0] ST_ROUND    = 2'b01;
  localparam logic [1:0] ST_MISMATCH = 2'b10;
  localparam logic [1:0] ST_ORPHAN   = 2'b11;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d;
  logic [1:0]       status_q, status_d;
  logic             status_valid_q, status_valid_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d, round_cnt_q, round_cnt_d;
  logic [CNT_W-1:0] mismatch_cnt_q, mismatch_cnt_d, orphan_cnt_q, orphan_cnt_d;
  logic             overflow_q, overflow_d, error_q, error_d;

  logic             full_c, empty_c, push_c, pop_c;
  logic [WIDTH-1:0] head_c;
  logic [1:0]       class_c;

  function automatic logic is_nan(input logic [WIDTH-1:0] x);
    return (&x[WIDTH-2:MANT_W]) && (|x[MANT_W-1:0]);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Queue status from the extra pointer MSB (wrap indicator).
  assign full_c  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                   (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign push_c  = exp_valid && !full_c;
  assign pop_c   = res_valid && !empty_c;
  assign head_c  = mem_q[rd_ptr_q[IDX_W-1:0]];

  // Classify the result against the queue head, highest priority first.
  always_comb begin
    class_c = ST_MISMATCH;
    if ((res_data == head_c) ||
        ((NAN_EQ != 0) && is_nan(res_data) && is_nan(head_c))) begin
      class_c = ST_EXACT;
    end else if (res_data[WIDTH-1:TOL_BITS] == head_c[WIDTH-1:TOL_BITS]) begin
      class_c = ST_ROUND;
    end
  end

  // Next-state: queue pointers, classification and statistics.
  always_comb begin
    mem_d          = mem_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    status_d       = status_q;
    status_valid_d = res_valid;
    match_cnt_d    = match_cnt_q;
    round_cnt_d    = round_cnt_q;
    mismatch_cnt_d = mismatch_cnt_q;
    orphan_cnt_d   = orphan_cnt_q;
    overflow_d     = overflow_q || (exp_valid && full_c);
    error_d        = error_q;

    if (push_c) begin
      mem_d[wr_ptr_q[IDX_W-1:0]] = exp_data;
      wr_ptr_d                   = wr_ptr_q + PTR_W'(1);
    end

    if (res_valid) begin
      if (empty_c) begin
        // Orphan: judged on the pre-edge queue, so a same-cycle push never pairs with it.
        status_d     = ST_ORPHAN;
        orphan_cnt_d = sat_inc(orphan_cnt_q);
        error_d      = 1'b1;
      end else begin
        status_d = class_c;
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case (class_c)
          ST_EXACT: match_cnt_d = sat_inc(match_cnt_q);
          ST_ROUND: round_cnt_d = sat_inc(round_cnt_q);
          default: begin
            mismatch_cnt_d = sat_inc(mismatch_cnt_q);
            error_d        = 1'b1;
          end
        endcase
      end
    end

    level_d = level_q + PTR_W'(push_c) - PTR_W'(pop_c);
  end

  // Control and statistics registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      status_q       <= ST_EXACT;
      status_valid_q <= 1'b0;
      match_cnt_q    <= '0;
      round_cnt_q    <= '0;
      mismatch_cnt_q <= '0;
      orphan_cnt_q   <= '0;
      overflow_q     <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      status_q       <= status_d;
      status_valid_q <= status_valid_d;
      match_cnt_q    <= match_cnt_d;
      round_cnt_q    <= round_cnt_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      orphan_cnt_q   <= orphan_cnt_d;
      overflow_q     <= overflow_d;
      error_q        <= error_d;
    end
  end

  // Queue storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  assign exp_ready    = !full_c;
  assign status_valid = status_valid_q;
  assign status       = status_q;
  assign match_cnt    = match_cnt_q;
  assign round_cnt    = round_cnt_q;
  assign mismatch_cnt = mismatch_cnt_q;
  assign orphan_cnt   = orphan_cnt_q;
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign error        = error_q;

endmodule

// File: tb/tb_fpu_result_checker.sv
// Testbench for fpu_result_checker: directed steps from the test plan followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_fpu_result_checker;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned EXP_W    = 8;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned TOL_BITS = 1;
  localparam int unsigned NAN_EQ   = 1;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned LVL_W    = $clog2(DEPTH) + 1;
  localparam int          CNT_MAX  = (1 << CNT_W) - 1;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              exp_valid = 1'b0;
  logic [WIDTH-1:0]  exp_data = '0;
  logic              exp_ready;
  logic              res_valid = 1'b0;
  logic [WIDTH-1:0]  res_data = '0;
  logic              status_valid;
  logic [1:0]        status;
  logic [CNT_W-1:0]  match_cnt, round_cnt, mismatch_cnt, orphan_cnt;
  logic [LVL_W-1:0]  level;
  logic              overflow, error;

  always #5 CLK = ~CLK;

  fpu_result_checker #(
    .WIDTH(WIDTH), .EXP_W(EXP_W), .DEPTH(DEPTH), .TOL_BITS(TOL_BITS),
    .NAN_EQ(NAN_EQ), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RST(RST),
    .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(exp_ready),
    .res_valid(res_valid), .res_data(res_data),
    .status_valid(status_valid), .status(status),
    .match_cnt(match_cnt), .round_cnt(round_cnt),
    .mismatch_cnt(mismatch_cnt), .orphan_cnt(orphan_cnt),
    .level(level), .overflow(overflow), .error(error)
  );

  // Reference model state
  logic [31:0] mq[$];
  int          m_cnt[4];
  logic [1:0]  m_status;
  bit          m_sv, m_ovf, m_err;

  int n_checks = 0;
  int n_errors = 0;

  function automatic bit f_is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Spec rules written directly as arithmetic on the values.
  function automatic logic [1:0] f_classify(input logic [31:0] e, input logic [31:0] r);
    if (r == e) return 2'd0;
    if (NAN_EQ != 0 && f_is_nan(r) && f_is_nan(e)) return 2'd0;
    if ((r >> TOL_BITS) == (e >> TOL_BITS)) return 2'd1;
    return 2'd2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all();
    chk("status_valid", 32'(status_valid), 32'(m_sv));
    chk("status", 32'(status), 32'(m_status));
    chk("match_cnt", 32'(match_cnt), 32'(m_cnt[0]));
    chk("round_cnt", 32'(round_cnt), 32'(m_cnt[1]));
    chk("mismatch_cnt", 32'(mismatch_cnt), 32'(m_cnt[2]));
    chk("orphan_cnt", 32'(orphan_cnt), 32'(m_cnt[3]));
    chk("level", 32'(level), 32'(mq.size()));
    chk("exp_ready", 32'(exp_ready), 32'(mq.size() != DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("error", 32'(error), 32'(m_err));
  endtask

  // Apply one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input bit rst, input bit ev, input logic [31:0] ed,
                      input bit rv, input logic [31:0] rd);
    bit          was_full, was_empty;
    logic [31:0] head;
    logic [1:0]  cls;
    RST = rst; exp_valid = ev; exp_data = ed; res_valid = rv; res_data = rd;
    if (rst) begin
      mq.delete();
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_status = 2'd0; m_sv = 0; m_ovf = 0; m_err = 0;
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      m_sv = rv;
      if (rv) begin
        if (was_empty) cls = 2'd3;
        else begin
          head = mq.pop_front();
          cls  = f_classify(head, rd);
        end
        m_status = cls;
        if (m_cnt[cls] < CNT_MAX) m_cnt[cls]++;
        if (cls >= 2'd2) m_err = 1;
      end
      if (ev) begin
        if (was_full) m_ovf = 1;
        else mq.push_back(ed);
      end
    end
    @(posedge CLK);
    #1;
    check_all();
  endtask

  task automatic idle();
    step(0, 0, 32'h0, 0, 32'h0);
  endtask

  initial begin
    logic [31:0] d, r;
    int          sel;

    // Reset
    step(1, 1, 32'h1234_5678, 1, 32'h1234_5678);
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_ready", 32'(exp_ready), 32'd1);

    // Exact match
    step(0, 1, 32'h40A0_0000, 0, 32'h0);
    step(0, 0, 32'h0, 1, 32'h40A0_0000);
    chk("exact_status", 32'(status), 32'd0);
    chk("exact_match_cnt", 32'(match_cnt), 32'd1);
    idle();
    chk("exact_pulse_end", 32'(status_valid), 32'd0);

    // Rounding, then a two-LSB difference that must be a mismatch
    step(0, 1, 32'h40A0_0000, 0, 32'h0);
    step(0, 0, 32'h0, 1, 32'h40A0_0001);
    chk("round_status", 32'(status), 32'd1);
    chk("round_error", 32'(error), 32'd0);
    step(0, 1, 32'h40A0_0000, 0, 32'h0);
    step(0, 0, 32'h0, 1, 32'h40A0_0002);
    chk("mism_status", 32'(status), 32'd2);
    chk("mism_error", 32'(error), 32'd1);

    // Ordering and full: 9 pushes, 9th dropped
    for (int i = 0; i < 9; i++) begin
      step(0, 1, 32'h3F80_0000 + 32'(i), 0, 32'h0);
      if (i == 7) chk("full_ready", 32'(exp_ready), 32'd0);
    end
    chk("full_level", 32'(level), 32'd8);
    chk("full_overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 32'h0, 1, 32'h3F80_0000 + 32'(i));
      chk("order_status", 32'(status), 32'd0);
    end
    chk("drain_level", 32'(level), 32'd0);

    // Orphan with same-cycle push, then the pushed value matches
    step(0, 1, 32'h4120_0000, 1, 32'h4120_0000);
    chk("orphan_status", 32'(status), 32'd3);
    chk("orphan_level", 32'(level), 32'd1);
    step(0, 0, 32'h0, 1, 32'h4120_0000);
    chk("after_orphan", 32'(status), 32'd0);

    // NaN equivalence and signed zero
    step(0, 1, 32'h7FC0_0000, 0, 32'h0);
    step(0, 0, 32'h0, 1, 32'h7F80_0001);
    chk("nan_status", 32'(status), 32'd0);
    step(0, 1, 32'h0000_0000, 0, 32'h0);
    step(0, 0, 32'h0, 1, 32'h8000_0000);
    chk("zero_status", 32'(status), 32'd2);

    // Counter saturation
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 32'h4000_0000 + 32'(i), 0, 32'h0);
      step(0, 0, 32'h0, 1, 32'h4000_0000 + 32'(i));
    end
    chk("sat_match_cnt", 32'(match_cnt), 32'(CNT_MAX));

    // Reset with entries queued discards them
    for (int i = 0; i < 3; i++) step(0, 1, 32'h4200_0000 + 32'(i), 0, 32'h0);
    step(1, 0, 32'h0, 0, 32'h0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    step(0, 0, 32'h0, 1, 32'h4200_0000);
    chk("rst_orphan", 32'(status), 32'd3);

    // Randomized traffic against the model
    step(1, 0, 32'h0, 0, 32'h0);
    for (int c = 0; c < 600; c++) begin
      bit ev, rv;
      ev = (c < 300) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
      rv = (c < 300) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
      d = $urandom;
      if ($urandom_range(0, 7) == 0) d = 32'h7F80_0001 | (32'($urandom) & 32'h807F_FFFF);
      r = $urandom;
      if (mq.size() > 0) begin
        sel = $urandom_range(0, 5);
        case (sel)
          0: r = mq[0];
          1: r = mq[0] ^ 32'h1;
          2: r = mq[0] ^ 32'h2;
          3: r = mq[0] ^ 32'h8000_0000;
          4: r = 32'h7F80_0001 | (32'($urandom) & 32'h807F_FFFF);
          default: r = $urandom;
        endcase
      end
      step(0, ev, d, rv, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
